// File: rtl/game_glyph_rom.sv
// game_glyph_rom: registered 8x8 glyph ROM serving digit and GAME OVER letter bitmaps
module game_glyph_rom #(
  parameter logic [3:0] SPACE_CODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  digit,
  output logic [63:0] digit_bmp,
  input  logic [3:0]  letter,
  output logic [63:0] letter_bmp
);
  logic [63:0] digit_rom;
  logic [63:0] letter_rom;
  // Row 0 sits in the low byte, so each constant reads bottom row first.
  always_comb begin
    digit_rom = '0;
    case (digit)
      4'd0: digit_rom = 64'h003C6666766E663C;
      4'd1: digit_rom = 64'h007E181818183818;
      4'd2: digit_rom = 64'h007E60300C06663C;
      4'd3: digit_rom = 64'h003C66061C06663C;
      4'd4: digit_rom = 64'h000C0C7E6C3C1C0C;
      4'd5: digit_rom = 64'h003C6606067C607E;
      4'd6: digit_rom = 64'h003C6666667C603C;
      4'd7: digit_rom = 64'h00303030180C067E;
      4'd8: digit_rom = 64'h003C66663C66663C;
      4'd9: digit_rom = 64'h00380C063E66663C;
      default: digit_rom = '0;
    endcase
  end
  always_comb begin
    letter_rom = '0;
    case (letter)
      4'd0: letter_rom = 64'h003C66666E60663C;
      4'd1: letter_rom = 64'h0066667E66663C18;
      4'd2: letter_rom = 64'h006363636B7F7763;
      4'd3: letter_rom = 64'h007E60607C60607E;
      4'd4: letter_rom = 64'h003C66666666663C;
      4'd5: letter_rom = 64'h00183C6666666666;
      4'd6: letter_rom = 64'h00666C787C66667C;
      default: letter_rom = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_bmp  <= '0;
      letter_bmp <= '0;
    end else begin
      digit_bmp  <= digit_rom;
      letter_bmp <= (letter == SPACE_CODE) ? '0 : letter_rom;
    end
  end
endmodule

// File: tb/tb_game_glyph_rom.sv
// tb_game_glyph_rom: scoreboard bench for the digit and letter glyph channels
module tb_game_glyph_rom;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  digit;
  logic [3:0]  letter;
  logic [63:0] digit_bmp;
  logic [63:0] letter_bmp;
  int checks = 0;
  int errors = 0;
  logic [63:0] dq[$];
  logic [63:0] lq[$];
  logic [63:0] ed, el;
  game_glyph_rom dut (
    .clk(clk),
    .rst_n(rst_n),
    .digit(digit),
    .digit_bmp(digit_bmp),
    .letter(letter),
    .letter_bmp(letter_bmp)
  );
  always #5 clk = ~clk;
  // Glyph rows top to bottom, eight bytes per code.
  localparam logic [0:79][7:0] DR = {
    8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00,
    8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00,
    8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00,
    8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00,
    8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00,
    8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00,
    8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00,
    8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00,
    8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00,
    8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00};
  localparam logic [0:55][7:0] LR = {
    8'h3C, 8'h66, 8'h60, 8'h6E, 8'h66, 8'h66, 8'h3C, 8'h00,
    8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00,
    8'h63, 8'h77, 8'h7F, 8'h6B, 8'h63, 8'h63, 8'h63, 8'h00,
    8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h7E, 8'h00,
    8'h3C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00,
    8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h18, 8'h00,
    8'h7C, 8'h66, 8'h66, 8'h7C, 8'h78, 8'h6C, 8'h66, 8'h00};
  function automatic logic [63:0] exp_digit(input logic [3:0] c);
    logic [63:0] g = '0;
    if (c < 4'd10) for (int r = 0; r < 8; r++) g[8*r +: 8] = DR[int'(c) * 8 + r];
    return g;
  endfunction
  function automatic logic [63:0] exp_letter(input logic [3:0] c);
    logic [63:0] g = '0;
    if (c < 4'd7) for (int r = 0; r < 8; r++) g[8*r +: 8] = LR[int'(c) * 8 + r];
    return g;
  endfunction
  // Drive on the falling edge, queue expectations, land on the next falling edge.
  task automatic drive(input logic [3:0] d, input logic [3:0] l, input logic r);
    digit = d;
    letter = l;
    rst_n = r;
    dq.push_back(r ? exp_digit(d) : 64'h0);
    lq.push_back(r ? exp_letter(l) : 64'h0);
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(4'd8, 4'd0, 1'b0);
      ed = dq.pop_front(); el = lq.pop_front();
      checks += 2;
      if (digit_bmp !== ed) begin errors++; $display("FAIL reset_digit got %h want %h", digit_bmp, ed); end
      if (letter_bmp !== el) begin errors++; $display("FAIL reset_letter got %h want %h", letter_bmp, el); end
    end
    drive(4'd8, 4'd0, 1'b1);
    ed = dq.pop_front(); el = lq.pop_front();
    checks += 3;
    if (digit_bmp !== ed) begin errors++; $display("FAIL release_digit got %h want %h", digit_bmp, ed); end
    if (digit_bmp !== 64'h003C66663C66663C) begin errors++; $display("FAIL release_eight got %h want 003c66663c66663c", digit_bmp); end
    if (letter_bmp !== el) begin errors++; $display("FAIL release_letter got %h want %h", letter_bmp, el); end
  endtask
  task automatic test_digit_sweep;
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 4'hF, 1'b1);
      ed = dq.pop_front(); el = lq.pop_front();
      checks += 2;
      if (digit_bmp !== ed) begin errors++; $display("FAIL digit_sweep code %0d got %h want %h", i, digit_bmp, ed); end
      if (letter_bmp !== el) begin errors++; $display("FAIL digit_sweep_letter code %0d got %h want %h", i, letter_bmp, el); end
    end
  endtask
  task automatic test_letter_sweep;
    for (int i = 0; i < 16; i++) begin
      drive(4'd1, 4'(i), 1'b1);
      ed = dq.pop_front(); el = lq.pop_front();
      checks += 2;
      if (letter_bmp !== el) begin errors++; $display("FAIL letter_sweep code %0d got %h want %h", i, letter_bmp, el); end
      if (digit_bmp !== ed) begin errors++; $display("FAIL letter_sweep_digit code %0d got %h want %h", i, digit_bmp, ed); end
      if (i == 2) begin
        checks++;
        if (letter_bmp !== 64'h006363636B7F7763) begin errors++; $display("FAIL letter_m got %h want 006363636b7f7763", letter_bmp); end
      end
    end
  endtask
  task automatic test_game_over;
    logic [3:0] seq [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'hF, 4'd4, 4'd5, 4'd3, 4'd6};
    for (int i = 0; i < 9; i++) begin
      drive(4'd0, seq[i], 1'b1);
      ed = dq.pop_front(); el = lq.pop_front();
      checks++;
      if (letter_bmp !== el) begin errors++; $display("FAIL game_over pos %0d got %h want %h", i, letter_bmp, el); end
    end
  endtask
  task automatic test_back_to_back;
    logic [3:0] ds [6] = '{4'd3, 4'd7, 4'd0, 4'd9, 4'd12, 4'd5};
    logic [3:0] ls [6] = '{4'd1, 4'd6, 4'd4, 4'hF, 4'd0, 4'd9};
    for (int i = 0; i < 6; i++) begin
      drive(ds[i], ls[i], 1'b1);
      ed = dq.pop_front(); el = lq.pop_front();
      checks += 2;
      if (digit_bmp !== ed) begin errors++; $display("FAIL both_digit step %0d got %h want %h", i, digit_bmp, ed); end
      if (letter_bmp !== el) begin errors++; $display("FAIL both_letter step %0d got %h want %h", i, letter_bmp, el); end
    end
  endtask
  task automatic test_mid_reset;
    for (int i = 0; i < 10; i++) begin
      drive(4'(i), 4'(i % 7), i != 4);
      ed = dq.pop_front(); el = lq.pop_front();
      checks += 2;
      if (digit_bmp !== ed) begin errors++; $display("FAIL mid_reset_digit step %0d got %h want %h", i, digit_bmp, ed); end
      if (letter_bmp !== el) begin errors++; $display("FAIL mid_reset_letter step %0d got %h want %h", i, letter_bmp, el); end
    end
  endtask
  initial begin
    rst_n = 1'b0;
    digit = 4'd0;
    letter = 4'd0;
    @(negedge clk);
    test_reset;
    test_digit_sweep;
    test_letter_sweep;
    test_game_over;
    test_back_to_back;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
